// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared definitions for the pipeline control unit: PC source encodings,
// the interrupt-entry state enum and the default drain depth.
package pipe_ctrl_pkg;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PC_SEL_SEQ    = 2'd0;
    localparam pc_sel_t PC_SEL_BRANCH = 2'd1;
    localparam pc_sel_t PC_SEL_VECTOR = 2'd2;
    localparam pc_sel_t PC_SEL_EPC    = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_VECT  = 2'd2
    } ctrl_state_t;

    localparam int DEFAULT_DRAIN_CYC = 3;
    localparam int DRAIN_CNT_W       = 4;

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// Bundle of hazard/redirect requests and the pipeline control outputs.
// master: the control unit (consumes requests, drives enables/flushes).
// slave: the pipeline side (drives requests, consumes enables/flushes).
interface pipeline_ctrl_unit_if;
    import pipe_ctrl_pkg::*;

    logic    Stall;
    logic    branch_taken;
    logic    mret;
    logic    irq;
    logic    pc_we;
    pc_sel_t pc_sel;
    logic    ifid_we;
    logic    ifid_flush;
    logic    idex_flush;
    logic    epc_we;
    logic    irq_ack;
    logic    in_isr;

    modport master (
        input  Stall, branch_taken, mret, irq,
        output pc_we, pc_sel, ifid_we, ifid_flush, idex_flush,
               epc_we, irq_ack, in_isr
    );

    modport slave (
        output Stall, branch_taken, mret, irq,
        input  pc_we, pc_sel, ifid_we, ifid_flush, idex_flush,
               epc_we, irq_ack, in_isr
    );

endinterface

// File: rtl/pipeline_ctrl_unit_event_counter.sv
// 32-bit event counter: increments when en is high, synchronous clear wins.
module pipe_event_counter (
    input  logic        clk,
    input  logic        clear,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Next count: clear has priority, otherwise wrap-around increment on en.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 32'd0;
        end else if (en) begin
            count_d = count_q + 32'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline control unit: turns load-use stalls, EX redirects and interrupt
// requests into PC / IF/ID / ID/EX enables, flushes and PC source select,
// and sequences interrupt entry (accept, drain, vector) and exit via mret.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall_cnt / flush_cnt.
module pipeline_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYC = DEFAULT_DRAIN_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    pipeline_ctrl_unit_if.master     bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt
`endif
);

    ctrl_state_t            state_q;
    ctrl_state_t            state_d;
    logic [DRAIN_CNT_W-1:0] cnt_q;
    logic [DRAIN_CNT_W-1:0] cnt_d;
    logic                   in_isr_q;
    logic                   in_isr_d;

    // RUN-state decisions shared by next-state, output and perf logic.
    logic run_mret;
    logic run_branch;
    logic run_accept;
    logic run_stall;

    assign run_mret   = (state_q == ST_RUN) && bus.mret;
    assign run_branch = (state_q == ST_RUN) && !bus.mret && bus.branch_taken;
    assign run_accept = (state_q == ST_RUN) && !bus.mret && !bus.branch_taken
                        && bus.irq && !in_isr_q;
    assign run_stall  = (state_q == ST_RUN) && !bus.mret && !bus.branch_taken
                        && !(bus.irq && !in_isr_q) && bus.Stall;

    // State, drain counter and handler flag; reset abandons any interrupt entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            in_isr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_isr_q <= in_isr_d;
        end
    end

    // Next state: accept loads the drain count, DRAIN counts down to VECT,
    // VECT enters the handler; mret leaves it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_isr_d = in_isr_q;
        case (state_q)
            ST_RUN: begin
                if (run_mret) begin
                    in_isr_d = 1'b0;
                end else if (run_accept) begin
                    cnt_d   = DRAIN_CNT_W'(DRAIN_CYC);
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = ST_VECT;
                end
            end
            ST_VECT: begin
                in_isr_d = 1'b1;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Pipeline control outputs, combinational from state and requests;
    // reset forces a frozen PC with bubbles in both pipeline registers.
    always_comb begin
        bus.pc_we      = 1'b0;
        bus.pc_sel     = PC_SEL_SEQ;
        bus.ifid_we    = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.epc_we     = 1'b0;
        bus.irq_ack    = 1'b0;
        if (rst) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (run_mret) begin
                        bus.pc_sel     = PC_SEL_EPC;
                        bus.pc_we      = 1'b1;
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                    end else if (run_branch) begin
                        bus.pc_sel     = PC_SEL_BRANCH;
                        bus.pc_we      = 1'b1;
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                    end else if (run_accept) begin
                        bus.epc_we     = 1'b1;
                        bus.irq_ack    = 1'b1;
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                    end else if (run_stall) begin
                        bus.idex_flush = 1'b1;
                    end else begin
                        bus.pc_we   = 1'b1;
                        bus.ifid_we = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    bus.ifid_flush = 1'b1;
                    bus.idex_flush = 1'b1;
                end
                ST_VECT: begin
                    bus.pc_sel     = PC_SEL_VECTOR;
                    bus.pc_we      = 1'b1;
                    bus.ifid_flush = 1'b1;
                    bus.idex_flush = 1'b1;
                end
                default: begin
                    bus.ifid_flush = 1'b1;
                    bus.idex_flush = 1'b1;
                end
            endcase
        end
    end

    assign bus.in_isr = in_isr_q;

`ifdef PIPE_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !rst && run_stall;
    assign flush_inc = !rst && (run_mret || run_branch);

    pipe_event_counter u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .en    (stall_inc),
        .count (stall_cnt)
    );

    pipe_event_counter u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .en    (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed self-checking bench for pipeline_ctrl_unit with DRAIN_CYC=3.
// Inputs change just after the falling edge; outputs are sampled 1 time
// unit later, well away from the rising edge.
module tb_pipeline_ctrl_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipeline_ctrl_unit_if bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipeline_ctrl_unit #(.DRAIN_CYC(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next cycle and drive this cycle's requests.
    task automatic next_cycle(input logic s, input logic b, input logic m, input logic i);
        @(negedge clk);
        bus.Stall        = s;
        bus.branch_taken = b;
        bus.mret         = m;
        bus.irq          = i;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.pc_we !== 1'b0 || bus.ifid_we !== 1'b0 || bus.ifid_flush !== 1'b1 ||
            bus.idex_flush !== 1'b1 || bus.pc_sel !== 2'd0 || bus.epc_we !== 1'b0 ||
            bus.irq_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got pc_we=%b ifid_we=%b iff=%b idf=%b sel=%0d epc=%b ack=%b want 0 0 1 1 0 0 0",
                     bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_flush, bus.pc_sel, bus.epc_we, bus.irq_ack);
        end
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.in_isr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_in_isr got %b want 0", bus.in_isr);
        end
        rst = 1'b0;
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.pc_we !== 1'b1 || bus.ifid_we !== 1'b1 || bus.pc_sel !== 2'd0 ||
            bus.ifid_flush !== 1'b0 || bus.idex_flush !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_run got pc_we=%b ifid_we=%b sel=%0d iff=%b idf=%b want 1 1 0 0 0",
                     bus.pc_we, bus.ifid_we, bus.pc_sel, bus.ifid_flush, bus.idex_flush);
        end
    endtask

    task automatic test_stall();
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.pc_we !== 1'b0 || bus.ifid_we !== 1'b0 || bus.idex_flush !== 1'b1 ||
            bus.ifid_flush !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_cycle got pc_we=%b ifid_we=%b idf=%b iff=%b want 0 0 1 0",
                     bus.pc_we, bus.ifid_we, bus.idex_flush, bus.ifid_flush);
        end
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.pc_we !== 1'b1 || bus.pc_sel !== 2'd0 || bus.idex_flush !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_release got pc_we=%b sel=%0d idf=%b want 1 0 0",
                     bus.pc_we, bus.pc_sel, bus.idex_flush);
        end
    endtask

    task automatic test_branch_priority();
        next_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.pc_sel !== 2'd1 || bus.pc_we !== 1'b1 || bus.ifid_flush !== 1'b1 ||
            bus.idex_flush !== 1'b1) begin
            failures++;
            $display("[TB] FAIL branch_over_stall got sel=%0d pc_we=%b iff=%b idf=%b want 1 1 1 1",
                     bus.pc_sel, bus.pc_we, bus.ifid_flush, bus.idex_flush);
        end
        next_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.pc_sel !== 2'd3 || bus.pc_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mret_over_branch got sel=%0d pc_we=%b want 3 1", bus.pc_sel, bus.pc_we);
        end
    endtask

    // Accept at t0, DRAIN t1..t3 with every request ignored, VECT at t4,
    // handler from t5 with irq still high, mret at t6, re-accept at t7.
    task automatic test_irq_entry();
        next_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.irq_ack !== 1'b1 || bus.epc_we !== 1'b1 || bus.pc_we !== 1'b0 ||
            bus.ifid_flush !== 1'b1 || bus.idex_flush !== 1'b1) begin
            failures++;
            $display("[TB] FAIL irq_accept got ack=%b epc=%b pc_we=%b iff=%b idf=%b want 1 1 0 1 1",
                     bus.irq_ack, bus.epc_we, bus.pc_we, bus.ifid_flush, bus.idex_flush);
        end
        for (int k = 1; k <= 3; k++) begin
            next_cycle(1'b1, 1'b1, 1'b1, 1'b1);
            checks++;
            if (bus.pc_we !== 1'b0 || bus.irq_ack !== 1'b0 || bus.ifid_flush !== 1'b1 ||
                bus.idex_flush !== 1'b1 || bus.pc_sel === 2'd2) begin
                failures++;
                $display("[TB] FAIL drain_t%0d got pc_we=%b ack=%b iff=%b idf=%b sel=%0d want 0 0 1 1 !=2",
                         k, bus.pc_we, bus.irq_ack, bus.ifid_flush, bus.idex_flush, bus.pc_sel);
            end
        end
        next_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.pc_sel !== 2'd2 || bus.pc_we !== 1'b1 || bus.ifid_flush !== 1'b1 ||
            bus.idex_flush !== 1'b1 || bus.in_isr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL vect_t4 got sel=%0d pc_we=%b iff=%b idf=%b in_isr=%b want 2 1 1 1 0",
                     bus.pc_sel, bus.pc_we, bus.ifid_flush, bus.idex_flush, bus.in_isr);
        end
        next_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.in_isr !== 1'b1 || bus.irq_ack !== 1'b0 || bus.pc_we !== 1'b1 || bus.pc_sel !== 2'd0) begin
            failures++;
            $display("[TB] FAIL isr_masked_t5 got in_isr=%b ack=%b pc_we=%b sel=%0d want 1 0 1 0",
                     bus.in_isr, bus.irq_ack, bus.pc_we, bus.pc_sel);
        end
        next_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.pc_sel !== 2'd3 || bus.pc_we !== 1'b1 || bus.irq_ack !== 1'b0 || bus.in_isr !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mret_t6 got sel=%0d pc_we=%b ack=%b in_isr=%b want 3 1 0 1",
                     bus.pc_sel, bus.pc_we, bus.irq_ack, bus.in_isr);
        end
        next_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.in_isr !== 1'b0 || bus.irq_ack !== 1'b1 || bus.epc_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reaccept_t7 got in_isr=%b ack=%b epc=%b want 0 1 1",
                     bus.in_isr, bus.irq_ack, bus.epc_we);
        end
    endtask

    // Called right after an accept cycle: reset lands in DRAIN.
    task automatic test_reset_mid_drain();
        int vec_seen;
        int ack_seen;
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.pc_we !== 1'b0 || bus.ifid_flush !== 1'b1 || bus.idex_flush !== 1'b1 ||
            bus.pc_sel !== 2'd0 || bus.irq_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_reset_outputs got pc_we=%b iff=%b idf=%b sel=%0d ack=%b want 0 1 1 0 0",
                     bus.pc_we, bus.ifid_flush, bus.idex_flush, bus.pc_sel, bus.irq_ack);
        end
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_isr !== 1'b0 || bus.pc_we !== 1'b1 || bus.ifid_we !== 1'b1 || bus.pc_sel !== 2'd0) begin
            failures++;
            $display("[TB] FAIL drain_reset_release got in_isr=%b pc_we=%b ifid_we=%b sel=%0d want 0 1 1 0",
                     bus.in_isr, bus.pc_we, bus.ifid_we, bus.pc_sel);
        end
        vec_seen = 0;
        ack_seen = 0;
        for (int k = 0; k < 6; k++) begin
            next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.pc_sel === 2'd2) vec_seen++;
            if (bus.irq_ack === 1'b1) ack_seen++;
        end
        checks++;
        if (vec_seen != 0 || ack_seen != 0) begin
            failures++;
            $display("[TB] FAIL aborted_entry got vector_cycles=%0d ack_cycles=%0d want 0 0", vec_seen, ack_seen);
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf_counters();
        rst = 1'b1;
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) next_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 32'd4 || flush_cnt !== 32'd2) begin
            failures++;
            $display("[TB] FAIL perf_counts got stall=%0d flush=%0d want 4 2", stall_cnt, flush_cnt);
        end
        rst = 1'b1;
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL perf_reset got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
        end
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        bus.Stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mret         = 1'b0;
        bus.irq          = 1'b0;
        test_reset();
        test_stall();
        test_branch_priority();
        test_irq_entry();
        test_reset_mid_drain();
`ifdef PIPE_CTRL_PERF_EN
        test_perf_counters();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl_unit.md
# pipeline_ctrl_unit

Consumes the load-use `Stall` request from the hazard detection unit, plus EX-stage redirect and external interrupt requests, and drives the pipeline register enables, flushes and PC source select. It turns "a hazard exists" into the concrete freeze, bubble, flush and redirect actions on PC, IF/ID and ID/EX. It also sequences interrupt entry: it accepts the request, drains the in-flight instructions, redirects to the vector and tracks in-handler state until `mret`.

## Interface

Parameters:
- `DRAIN_CYC`, default 3. Cycles to let older in-flight instructions (EX/MEM/WB) retire before vectoring. Legal range is 1..15.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `Stall`  input  1  load-use hazard request from the hazard detection unit.
- `branch_taken`  input  1  EX-stage taken branch or jump.
- `mret`  input  1  EX-stage `mret`.
- `irq`  input  1  level-sensitive external interrupt request.
- `pc_we`  output  1  PC register write enable.
- `pc_sel`  output  2  PC source: 0 SEQ, 1 BRANCH, 2 VECTOR, 3 EPC.
- `ifid_we`  output  1  IF/ID write enable.
- `ifid_flush`  output  1  load a bubble into IF/ID.
- `idex_flush`  output  1  load a bubble into ID/EX.
- `epc_we`  output  1  one-cycle pulse; the external EPC register captures the ID-stage PC.
- `irq_ack`  output  1  one-cycle acceptance pulse, coincident with `epc_we`.
- `in_isr`  output  1  registered flag, high while the handler runs.

## Operation

- States: RUN, DRAIN, VECT. A drain down-counter and the `in_isr` flag are the only other state.
- RUN resolves one action per cycle, in this priority order:
  - `mret`: `pc_sel`=EPC, `pc_we`=1, `ifid_flush`=1, `idex_flush`=1, clear `in_isr`.
  - `branch_taken`: `pc_sel`=BRANCH, `pc_we`=1, `ifid_flush`=1, `idex_flush`=1.
  - Accept (`irq` && !`in_isr`):
    - Pulse `epc_we`/`irq_ack`.
    - Set `pc_we`=0, `ifid_flush`=1, `idex_flush`=1.
    - Load the counter with `DRAIN_CYC` and go to DRAIN.
    - The squashed ID instruction re-executes on return.
  - `Stall`: `pc_we`=0, `ifid_we`=0, `idex_flush`=1. PC and IF/ID hold, ID/EX gets a bubble.
  - Otherwise: `pc_sel`=SEQ, `pc_we`=1, `ifid_we`=1, no flushes.
- DRAIN:
  - `pc_we`=0, `ifid_flush`=1, `idex_flush`=1.
  - Decrement the counter each cycle; at count 1, go to VECT.
  - `Stall`, `branch_taken`, `mret` and `irq` are ignored; the pipeline holds only bubbles.
- VECT (one cycle): `pc_sel`=VECTOR, `pc_we`=1, `ifid_flush`=1, `idex_flush`=1, set `in_isr`, go to RUN.
- When a flush and a write enable are both asserted, the flush wins at the pipeline register.
- `irq` is masked while `in_isr`=1 (no nesting). A still-asserted `irq` is taken on the first RUN cycle after the `mret` cycle.
- If `mret` and `branch_taken` arrive together, `mret` wins. This is a fault case only.

## Timing

- Outputs are combinational from state and inputs, with no added latency. State, counter and `in_isr` update on the `clk` edge.
- Interrupt latency: accept cycle, then `DRAIN_CYC` DRAIN cycles, then the VECT cycle. The first handler fetch occurs `DRAIN_CYC`+2 cycles after the accept edge.
- `Stall` costs exactly one bubble per asserted cycle.
- Reset:
  - While `rst`=1, outputs are forced to `pc_we`=0, `ifid_we`=0, `ifid_flush`=1, `idex_flush`=1, `pc_sel`=SEQ, `epc_we`=0, `irq_ack`=0.
  - On the next edge: state=RUN, counter=0, `in_isr`=0.
- Reset mid-DRAIN or mid-VECT aborts the entry with no vector redirect and no later `irq_ack`.

## Configuration

- `PIPE_CTRL_PERF_EN` defined:
  - Adds outputs `stall_cnt[31:0]` and `flush_cnt[31:0]`.
  - `stall_cnt` increments on each RUN cycle where the `Stall` action is taken.
  - `flush_cnt` increments on each `branch_taken` or `mret` redirect.
  - Both counters wrap and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure

- Package `pipe_ctrl_pkg` holds:
  - the `pc_sel` encoding constants (SEQ/BRANCH/VECTOR/EPC);
  - the state enum (RUN/DRAIN/VECT);
  - the default drain depth.
- Sub-module `pipe_event_counter` (32-bit, enable-increment, synchronous clear) is instantiated twice, under `PIPE_CTRL_PERF_EN` only.

## Test plan

- `Stall`=1 for 1 cycle in RUN → `pc_we`=0, `ifid_we`=0, `idex_flush`=1 that cycle; next cycle `pc_we`=1, `pc_sel`=0.
- `branch_taken`=1 together with `Stall`=1 → `pc_sel`=1, `pc_we`=1, both flushes=1; the stall is ignored.
- `irq`=1 in RUN with `DRAIN_CYC`=3 → `irq_ack`/`epc_we` pulse at t0, three DRAIN cycles with `pc_we`=0, VECT at t4 with `pc_sel`=2, `in_isr`=1 from t5.
- `irq` held high in the handler, then `mret` → no `irq_ack` while `in_isr`=1; at `mret`, `pc_sel`=3 and `in_isr` clears; re-accept on the next cycle.
- `rst` asserted during DRAIN → outputs take reset values; after release, state=RUN, `in_isr`=0, no VECTOR redirect.
- `PIPE_CTRL_PERF_EN`: 4 stall cycles and 2 branches → `stall_cnt`=4, `flush_cnt`=2; `rst` clears both to 0.
